// File: rtl/serdesphy_deserializer_if.sv
// serdesphy_deserializer_if
//   RX-side control and qualification of the analog deserializer, in the 240 MHz RX domain.
//   It sequences the analog reset and enable, waits for lock and lets the lock settle.
//   It qualifies the recovered bit stream, counts error cycles and watches for loss of signal.
// Ports
//   clk_240m_rx, rst_n_240m_rx          : RX clock, async active-low reset
//   rx_en, deserializer_bypass          : CSR controls (synchronous to clk)
//   deserializer_data_in                : recovered bit from analog
//   deserializer_ready/_error           : analog lock / error flags (async, synchronized here)
//   deserializer_enable/_reset_n        : controls to analog
//   rx_serial_data/_valid               : qualified bit stream to rx_top
//   deserializer_active/_status         : status to rx_top / CSR
//   los_detect, if_error                : loss-of-signal and sticky interface error
module serdesphy_deserializer_if #(
  parameter int unsigned RESET_CYCLES  = 4,
  parameter int unsigned LOCK_TIMEOUT  = 1023,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned ERR_LIMIT     = 7,
  parameter int unsigned RUN_MAX       = 64
) (
  input  logic clk_240m_rx,
  input  logic rst_n_240m_rx,
  input  logic rx_en,
  input  logic deserializer_bypass,
  input  logic deserializer_data_in,
  input  logic deserializer_ready,
  input  logic deserializer_error,
  output logic deserializer_enable,
  output logic deserializer_reset_n,
  output logic rx_serial_data,
  output logic rx_serial_valid,
  output logic deserializer_active,
  output logic deserializer_status,
  output logic los_detect,
  output logic if_error
);

  localparam int unsigned CNT_MAX_A = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_MAX   = (LOCK_TIMEOUT > CNT_MAX_A) ? LOCK_TIMEOUT : CNT_MAX_A;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
  localparam int unsigned ERR_W     = $clog2(ERR_LIMIT + 1);
  localparam int unsigned RUN_W     = $clog2(RUN_MAX + 1);

  localparam logic [2:0] ST_DISABLED  = 3'd0;
  localparam logic [2:0] ST_RESET     = 3'd1;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd2;
  localparam logic [2:0] ST_SETTLE    = 3'd3;
  localparam logic [2:0] ST_ACTIVE    = 3'd4;
  localparam logic [2:0] ST_STOPPING  = 3'd5;
  localparam logic [2:0] ST_ERROR     = 3'd6;

  logic             ready_m, ready_s, error_m, error_s;
  logic             data_q, data_prev;
  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [ERR_W-1:0] err_cnt, err_cnt_nxt;
  logic [RUN_W-1:0] run_cnt, run_nxt;
  logic             abort;
  logic             valid_nxt;

  // Input synchronizers for the async analog flags; data is sampled once per cycle
  always_ff @(posedge clk_240m_rx or negedge rst_n_240m_rx) begin
    if (!rst_n_240m_rx) begin
      ready_m   <= 1'b0;
      ready_s   <= 1'b0;
      error_m   <= 1'b0;
      error_s   <= 1'b0;
      data_q    <= 1'b0;
      data_prev <= 1'b0;
    end else begin
      ready_m   <= deserializer_ready;
      ready_s   <= ready_m;
      error_m   <= deserializer_error;
      error_s   <= error_m;
      data_q    <= deserializer_data_in;
      data_prev <= data_q;
    end
  end

  assign abort = !rx_en || deserializer_bypass;

  // Next-state, counters and registered-output decode
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    err_cnt_nxt = err_cnt;
    run_nxt     = '0;
    case (state)
      ST_DISABLED: begin
        if (rx_en && !deserializer_bypass) begin
          state_nxt = ST_RESET;
          cnt_nxt   = '0;
        end
      end
      ST_RESET: begin
        if (abort) begin
          state_nxt = ST_DISABLED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_W'(RESET_CYCLES - 1)) begin
          state_nxt = ST_WAIT_LOCK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        if (abort) begin
          state_nxt = ST_DISABLED;
          cnt_nxt   = '0;
        end else if (ready_s) begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_W'(LOCK_TIMEOUT)) begin
          state_nxt = ST_ERROR;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_nxt = ST_DISABLED;
          cnt_nxt   = '0;
        end else if (!ready_s) begin
          state_nxt = ST_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_nxt   = ST_ACTIVE;
          cnt_nxt     = '0;
          err_cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_ACTIVE: begin
        // Leaving on rx_en/bypass wins over an error reaching the limit in the same cycle
        if (abort) begin
          state_nxt = ST_STOPPING;
          cnt_nxt   = '0;
        end else if (error_s || !ready_s) begin
          if (err_cnt != ERR_W'(ERR_LIMIT)) begin
            err_cnt_nxt = err_cnt + 1'b1;
          end
          if (err_cnt_nxt == ERR_W'(ERR_LIMIT)) begin
            state_nxt = ST_ERROR;
          end
        end
      end
      ST_STOPPING: begin
        if (cnt == CNT_W'(RESET_CYCLES - 1)) begin
          state_nxt = ST_DISABLED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_ERROR: begin
        if (!rx_en) begin
          state_nxt   = ST_DISABLED;
          cnt_nxt     = '0;
          err_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt = ST_ERROR;
        cnt_nxt   = '0;
      end
    endcase

    // Run length of identical bits; only counts while staying in ACTIVE
    if (state == ST_ACTIVE && state_nxt == ST_ACTIVE) begin
      if (data_q != data_prev) begin
        run_nxt = RUN_W'(1);
      end else if (run_cnt != RUN_W'(RUN_MAX)) begin
        run_nxt = run_cnt + 1'b1;
      end else begin
        run_nxt = run_cnt;
      end
    end

    valid_nxt = (state_nxt == ST_ACTIVE) || deserializer_bypass;
  end

  // State, counters and all outputs, decoded from the next state so they switch with it
  always_ff @(posedge clk_240m_rx or negedge rst_n_240m_rx) begin
    if (!rst_n_240m_rx) begin
      state                <= ST_DISABLED;
      cnt                  <= '0;
      err_cnt              <= '0;
      run_cnt              <= '0;
      deserializer_enable  <= 1'b0;
      deserializer_reset_n <= 1'b1;
      rx_serial_data       <= 1'b0;
      rx_serial_valid      <= 1'b0;
      deserializer_active  <= 1'b0;
      deserializer_status  <= 1'b0;
      los_detect           <= 1'b0;
      if_error             <= 1'b0;
    end else begin
      state                <= state_nxt;
      cnt                  <= cnt_nxt;
      err_cnt              <= err_cnt_nxt;
      run_cnt              <= run_nxt;
      deserializer_enable  <= (state_nxt == ST_WAIT_LOCK) || (state_nxt == ST_SETTLE) ||
                              (state_nxt == ST_ACTIVE) || (state_nxt == ST_STOPPING);
      deserializer_reset_n <= !((state_nxt == ST_DISABLED) || (state_nxt == ST_RESET));
      rx_serial_data       <= valid_nxt & data_q;
      rx_serial_valid      <= valid_nxt;
      deserializer_active  <= (state_nxt == ST_ACTIVE) || (state_nxt == ST_STOPPING);
      deserializer_status  <= ready_s & ~error_s;
      los_detect           <= (run_nxt == RUN_W'(RUN_MAX));
      if_error             <= (state_nxt == ST_ERROR);
    end
  end

endmodule

// File: tb/tb_serdesphy_deserializer_if.sv
// tb_serdesphy_deserializer_if
//   Random data stream scored against a two-cycle reference pipeline, plus timed
//   checks of the reset/lock/settle/error/LOS sequencing derived from the cycle rules.
`timescale 1ns/1ps
module tb_serdesphy_deserializer_if;

  localparam int unsigned RESET_CYCLES  = 4;
  localparam int unsigned LOCK_TIMEOUT  = 1023;
  localparam int unsigned SETTLE_CYCLES = 8;
  localparam int unsigned ERR_LIMIT     = 7;
  localparam int unsigned RUN_MAX       = 64;
  // input sample + second sync flop + WAIT_LOCK exit, then the settle window
  localparam int LOCK_TO_ACTIVE = 3 + SETTLE_CYCLES;

  logic clk = 1'b0;
  logic rst_n, rx_en, bypass, data_in, ready, error;
  logic enable, reset_n, rx_data, rx_valid, active, status, los, if_error;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int c0, at, at2, rr, lpt;
  logic q_bits[$];
  logic los_mode = 1'b0;
  logic los_bit  = 1'b1;
  logic exp_bit;

  serdesphy_deserializer_if #(
    .RESET_CYCLES(RESET_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT), .SETTLE_CYCLES(SETTLE_CYCLES),
    .ERR_LIMIT(ERR_LIMIT), .RUN_MAX(RUN_MAX)
  ) dut (
    .clk_240m_rx(clk), .rst_n_240m_rx(rst_n), .rx_en(rx_en), .deserializer_bypass(bypass),
    .deserializer_data_in(data_in), .deserializer_ready(ready), .deserializer_error(error),
    .deserializer_enable(enable), .deserializer_reset_n(reset_n), .rx_serial_data(rx_data),
    .rx_serial_valid(rx_valid), .deserializer_active(active), .deserializer_status(status),
    .los_detect(los), .if_error(if_error)
  );

  always #2 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic get_sig(input int sel);
    case (sel)
      0:       return reset_n;
      1:       return active;
      2:       return if_error;
      3:       return los;
      4:       return enable;
      default: return rx_valid;
    endcase
  endfunction

  // Poll once per cycle on the falling edge until the selected output equals val
  task automatic wait_sig(input int sel, input logic val, input int budget, input string name,
                          output int when);
    when = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (get_sig(sel) === val) begin
        when = cyc;
        break;
      end
    end
    if (when < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: timeout after %0d cycles", name, budget);
    end
  endtask

  // Stimulus side of the scoreboard: every driven bit is queued
  initial begin
    data_in = 1'b0;
    forever begin
      @(negedge clk);
      #0.5;
      data_in = los_mode ? los_bit : 1'($urandom);
      q_bits.push_back(data_in);
    end
  end

  // Checking side: output after edge N carries the bit driven before edge N-1
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q_bits.size() >= 2) begin
        exp_bit = q_bits.pop_front();
        if (rx_valid) check("rx_data", rx_data, exp_bit);
        else          check("rx_data_idle", rx_data, 1'b0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; rx_en = 1'b0; bypass = 1'b0; ready = 1'b0; error = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_reset_n", reset_n, 1'b1);
    check("rst_enable", enable, 1'b0);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_data", rx_data, 1'b0);
    check("rst_active", active, 1'b0);
    check("rst_status", status, 1'b0);
    check("rst_los", los, 1'b0);
    check("rst_if_error", if_error, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("disabled_reset_n", reset_n, 1'b0);

    // T6: bypass from DISABLED, data streamed through with two-cycle latency
    bypass = 1'b1;
    @(negedge clk);
    check("bypass_valid", rx_valid, 1'b1);
    repeat (20) @(negedge clk);
    rx_en = 1'b1;
    repeat (20) @(negedge clk);
    check("bypass_hold_reset_n", reset_n, 1'b0);
    check("bypass_hold_enable", enable, 1'b0);
    rx_en = 1'b0; bypass = 1'b0;
    @(negedge clk);
    check("bypass_off_valid", rx_valid, 1'b0);

    // T1: reset pulse length, then lock + settle latency
    rx_en = 1'b1; c0 = cyc;
    wait_sig(0, 1'b1, 20, "reset_n_rise", at);
    check("reset_len", at - c0, 1 + RESET_CYCLES);
    check("wait_lock_enable", enable, 1'b1);
    while (cyc < c0 + 20) @(negedge clk);
    ready = 1'b1; rr = cyc;
    wait_sig(1, 1'b1, 40, "active_rise", at);
    check("settle_latency", at - rr, LOCK_TO_ACTIVE);
    check("active_valid", rx_valid, 1'b1);
    check("active_status", status, 1'b1);
    repeat (20) @(negedge clk);
    check("los_random", los, 1'b0);

    // T5: constant ones raise LOS after RUN_MAX samples; one zero clears it
    los_mode = 1'b1; los_bit = 1'b0; lpt = cyc;
    @(negedge clk);
    los_bit = 1'b1;
    wait_sig(3, 1'b1, 100, "los_rise", at);
    check("los_rise_time", at - lpt, RUN_MAX + 2);
    los_bit = 1'b0; lpt = cyc;
    @(negedge clk);
    los_bit = 1'b1;
    wait_sig(3, 1'b0, 10, "los_clear", at);
    check("los_clear_time", at - lpt, 2);
    wait_sig(3, 1'b1, 100, "los_rerise", at);
    check("los_rerise_time", at - lpt, RUN_MAX + 2);

    // Leaving ACTIVE: valid and LOS drop at once, enable held RESET_CYCLES
    rx_en = 1'b0; c0 = cyc;
    @(negedge clk);
    check("stop_valid", rx_valid, 1'b0);
    check("stop_active_hold", active, 1'b1);
    check("stop_los", los, 1'b0);
    wait_sig(4, 1'b0, 20, "stop_enable_fall", at);
    check("stop_len", at - c0, 1 + RESET_CYCLES);
    check("stop_active_off", active, 1'b0);
    los_mode = 1'b0;

    // T3: ready glitch during SETTLE sends it back to WAIT_LOCK
    ready = 1'b0;
    repeat (3) @(negedge clk);
    rx_en = 1'b1;
    wait_sig(0, 1'b1, 20, "t3_reset_n_rise", at);
    ready = 1'b1; rr = cyc;
    while (cyc < rr + 5) @(negedge clk);
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("glitch_no_valid", rx_valid, 1'b0);
    end
    ready = 1'b1; rr = cyc;
    wait_sig(1, 1'b1, 40, "t3_active_rise", at);
    check("glitch_settle_latency", at - rr, LOCK_TO_ACTIVE);

    // T4a: ERR_LIMIT-1 bad cycles keep ACTIVE
    repeat (5) @(negedge clk);
    error = 1'b1;
    repeat (ERR_LIMIT - 1) @(negedge clk);
    error = 1'b0;
    repeat (10) @(negedge clk);
    check("err6_active", active, 1'b1);
    check("err6_if_error", if_error, 1'b0);
    check("err6_enable", enable, 1'b1);

    // Restart to clear the error count; ready already stable high
    rx_en = 1'b0;
    wait_sig(4, 1'b0, 20, "restart_enable_fall", at);
    rx_en = 1'b1; c0 = cyc;
    wait_sig(1, 1'b1, 60, "relock_active", at);
    check("relock_latency", at - c0, 1 + RESET_CYCLES + 1 + SETTLE_CYCLES);

    // T4b: ERR_LIMIT bad cycles force ERROR
    repeat (5) @(negedge clk);
    error = 1'b1; c0 = cyc;
    for (int i = 0; i < int'(ERR_LIMIT); i++) begin
      @(negedge clk);
      if (i == 3) check("err_status", status, 1'b0);
    end
    error = 1'b0;
    wait_sig(2, 1'b1, 20, "err7_if_error", at);
    check("err7_time", at - c0, 2 + ERR_LIMIT);
    check("err7_enable", enable, 1'b0);
    check("err7_active", active, 1'b0);
    check("err7_valid", rx_valid, 1'b0);
    rx_en = 1'b0;
    @(negedge clk);
    check("err_clear", if_error, 1'b0);

    // T2: lock timeout
    ready = 1'b0;
    repeat (3) @(negedge clk);
    rx_en = 1'b1;
    wait_sig(0, 1'b1, 20, "t2_reset_n_rise", at);
    wait_sig(2, 1'b1, LOCK_TIMEOUT + 20, "timeout_if_error", at2);
    check("timeout_time", at2 - at, LOCK_TIMEOUT + 1);
    check("timeout_enable", enable, 1'b0);
    rx_en = 1'b0;
    @(negedge clk);
    check("timeout_clear", if_error, 1'b0);

    // Async reset in ACTIVE: immediate reset values, full sequence restarts
    ready = 1'b1; rx_en = 1'b1;
    wait_sig(1, 1'b1, 60, "pre_reset_active", at);
    #1 rst_n = 1'b0;
    #0.5;
    check("async_reset_n", reset_n, 1'b1);
    check("async_enable", enable, 1'b0);
    check("async_active", active, 1'b0);
    check("async_valid", rx_valid, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; c0 = cyc;
    @(negedge clk);
    check("post_reset_reset_n", reset_n, 1'b0);
    wait_sig(0, 1'b1, 20, "post_reset_reset_n_rise", at);
    check("post_reset_len", at - c0, 1 + RESET_CYCLES);
    wait_sig(1, 1'b1, 40, "post_reset_active", at);
    check("post_reset_active_time", at - c0, 1 + RESET_CYCLES + 1 + SETTLE_CYCLES);
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
